// File: rtl/fnd_pkg.sv
// ============================================================================
//  Module      : fnd_pkg
//  Description : Shared FND (7-segment, common-anode) pattern and digit codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fnd_pkg;

    // Active-low segment patterns, bit0=a .. bit6=g, bit7=dp (off)
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    // Active-low one-hot digit enables
    localparam logic [3:0] COM_DIG0  = 4'b1110;
    localparam logic [3:0] COM_DIG1  = 4'b1101;
    localparam logic [3:0] COM_DIG2  = 4'b1011;
    localparam logic [3:0] COM_DIG3  = 4'b0111;
    localparam logic [3:0] COM_BLANK = 4'b1111;

    localparam int DEF_SETTLE_CYC  = 4;
    localparam int DEF_TIMEOUT_CYC = 1_000_000;

    typedef logic [1:0] digit_idx_t;

    // Forward mapping used by the display-side driver
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_to_hex.sv
// ============================================================================
//  Module      : seg7_to_hex
//  Description : Inverse 7-segment decoder; flags patterns that are not 0-F.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_hex
    import fnd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       legal
);

    always_comb begin
        hex   = 4'h0;
        legal = 1'b1;
        case (seg)
            SEG_0[6:0]: hex = 4'h0;
            SEG_1[6:0]: hex = 4'h1;
            SEG_2[6:0]: hex = 4'h2;
            SEG_3[6:0]: hex = 4'h3;
            SEG_4[6:0]: hex = 4'h4;
            SEG_5[6:0]: hex = 4'h5;
            SEG_6[6:0]: hex = 4'h6;
            SEG_7[6:0]: hex = 4'h7;
            SEG_8[6:0]: hex = 4'h8;
            SEG_9[6:0]: hex = 4'h9;
            SEG_A[6:0]: hex = 4'hA;
            SEG_B[6:0]: hex = 4'hB;
            SEG_C[6:0]: hex = 4'hC;
            SEG_D[6:0]: hex = 4'hD;
            SEG_E[6:0]: hex = 4'hE;
            SEG_F[6:0]: hex = 4'hF;
            default: begin
                hex   = 4'h0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fnd_scan_decoder.sv
// ============================================================================
//  Module      : fnd_scan_decoder
//  Description : Passive monitor of a multiplexed 4-digit FND bus; rebuilds
//                the displayed 16-bit hex value frame by frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = 20
)(
    input  logic        clk,
    input  logic        reset_p,
    input  logic [7:0]  seg_7,
    input  logic [3:0]  com,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        value_changed,
    output logic        stale,
    output logic [3:0]  digit_mask
);

    localparam int                    c_SETTLE_W   = $clog2(SETTLE_CYC);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_MAX = c_SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]      c_TMO_MAX    = CNT_W'(TIMEOUT_CYC - 1);

    logic [7:0]            r_seg_q;
    logic [3:0]            r_com_q;
    logic [7:0]            r_seg_prev;
    logic [3:0]            r_com_prev;
    logic [c_SETTLE_W-1:0] r_settle;
    logic                  r_taken;
    logic [15:0]           r_asm;
    logic                  r_err_acc;
    logic [CNT_W-1:0]      r_tmo;

    logic                  w_stable;
    logic                  w_com_legal;
    digit_idx_t            w_idx;
    logic [3:0]            w_hex;
    logic                  w_seg_legal;
    logic                  w_capture;

    seg7_to_hex u_dec (
        .seg   (r_seg_q[6:0]),
        .hex   (w_hex),
        .legal (w_seg_legal)
    );

    always_comb begin
        w_com_legal = 1'b1;
        w_idx       = 2'd0;
        case (r_com_q)
            COM_DIG0: w_idx = 2'd0;
            COM_DIG1: w_idx = 2'd1;
            COM_DIG2: w_idx = 2'd2;
            COM_DIG3: w_idx = 2'd3;
            default:  w_com_legal = 1'b0;
        endcase
    end

    assign w_stable  = (r_seg_q == r_seg_prev) && (r_com_q == r_com_prev);
    // One capture per dwell: taken holds off repeats until the bus changes.
    assign w_capture = w_stable && (r_settle == c_SETTLE_MAX) && !r_taken && w_com_legal;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_seg_q       <= 8'hFF;
            r_com_q       <= 4'hF;
            r_seg_prev    <= 8'hFF;
            r_com_prev    <= 4'hF;
            r_settle      <= '0;
            r_taken       <= 1'b0;
            r_asm         <= 16'h0000;
            r_err_acc     <= 1'b0;
            r_tmo         <= '0;
            value         <= 16'h0000;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            value_changed <= 1'b0;
            stale         <= 1'b0;
            digit_mask    <= 4'h0;
        end else begin
            r_seg_q       <= seg_7;
            r_com_q       <= com;
            r_seg_prev    <= r_seg_q;
            r_com_prev    <= r_com_q;
            frame_valid   <= 1'b0;
            value_changed <= 1'b0;

            if (!w_stable) begin
                r_settle <= '0;
                r_taken  <= 1'b0;
            end else if (r_settle != c_SETTLE_MAX) begin
                r_settle <= r_settle + 1'b1;
            end

            if (w_capture) begin
                r_tmo <= '0;
            end else if (r_tmo != c_TMO_MAX) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_capture) begin
                r_taken                <= 1'b1;
                r_asm[{w_idx, 2'b00} +: 4] <= w_hex;
                digit_mask[w_idx]      <= 1'b1;
                r_err_acc              <= r_err_acc | ~w_seg_legal;
            end else if (digit_mask == 4'hF) begin
                value         <= r_asm;
                frame_err     <= r_err_acc;
                frame_valid   <= 1'b1;
                value_changed <= !r_err_acc && (r_asm != value);
                stale         <= 1'b0;
                digit_mask    <= 4'h0;
                r_err_acc     <= 1'b0;
            end else if (r_tmo == c_TMO_MAX) begin
                // Partial frame is discarded; the last good value is kept.
                stale      <= 1'b1;
                digit_mask <= 4'h0;
                r_err_acc  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_decoder.sv
// ============================================================================
//  Module      : tb_fnd_scan_decoder
//  Description : Self-checking bench for fnd_scan_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fnd_scan_decoder;

    logic        clk = 1'b0;
    logic        reset_p;
    logic [7:0]  seg_7;
    logic [3:0]  com;
    logic [15:0] value;
    logic        frame_valid;
    logic        frame_err;
    logic        value_changed;
    logic        stale;
    logic [3:0]  digit_mask;

    fnd_scan_decoder #(
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (64),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .reset_p       (reset_p),
        .seg_7         (seg_7),
        .com           (com),
        .value         (value),
        .frame_valid   (frame_valid),
        .frame_err     (frame_err),
        .value_changed (value_changed),
        .stale         (stale),
        .digit_mask    (digit_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        logic        e;
        logic        c;
    } frame_t;

    typedef struct {
        logic [7:0]  s3, s2, s1, s0;
        logic [15:0] v;
        logic        e;
        logic        c;
    } vec_t;

    frame_t     obs_q[$];
    frame_t     exp_q[$];
    vec_t       tbl[9];
    logic [7:0] pat[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int   tests = 0;
    int   fails = 0;
    int   stray = 0;
    logic prev_fv = 1'b0;

    always @(negedge clk) begin
        if (frame_valid) obs_q.push_back('{value, frame_err, value_changed});
        if (value_changed && !frame_valid) stray++;
        if (frame_valid && prev_fv) stray++;
        prev_fv = frame_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic dwell(input logic [3:0] c, input logic [7:0] s, input int n);
        com   = c;
        seg_7 = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] s3, s2, s1, s0);
        dwell(4'b0111, s3, 10);
        dwell(4'b1011, s2, 10);
        dwell(4'b1101, s1, 10);
        dwell(4'b1110, s0, 10);
        dwell(4'b1111, 8'hFF, 3);
    endtask

    task automatic check_one_frame(input string name, input logic [15:0] v,
                                   input logic e, input logic c);
        frame_t f;
        chk({name, "_count"}, 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) begin
            f = obs_q.pop_front();
            chk({name, "_value"}, 32'(f.v), 32'(v));
            chk({name, "_err"},   32'(f.e), 32'(e));
            chk({name, "_chg"},   32'(f.c), 32'(c));
        end
        obs_q.delete();
    endtask

    // Reference decode: look the 7 segment bits up in the hex table
    function automatic void ref_decode(input logic [7:0] s, output logic [3:0] h,
                                       output logic ok);
        logic [7:0] p;
        h  = 4'h0;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            p = pat[i];
            if (p[6:0] == s[6:0]) begin
                h  = 4'(i);
                ok = 1'b1;
            end
        end
    endfunction

    initial begin
        int          k;
        logic [3:0]  rc, prev_c;
        logic [7:0]  rs, prev_s;
        int          hold, kind, nc, dig;
        logic        capt, ok;
        logic [3:0]  h;
        logic [3:0]  m_nib[4];
        logic [3:0]  m_mask;
        logic        m_err;
        logic [15:0] m_val, m_word;
        logic [3:0]  blanks[4] = '{4'b1111, 4'b0011, 4'b0000, 4'b1001};

        tbl[0] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 16'h0123, 1'b0, 1'b1};
        tbl[1] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 16'h0123, 1'b0, 1'b0};
        tbl[2] = '{8'h8E, 8'h86, 8'hFF, 8'hA1, 16'hFE0D, 1'b1, 1'b0};
        tbl[3] = '{8'h88, 8'h83, 8'hC6, 8'hA1, 16'hABCD, 1'b0, 1'b1};
        tbl[4] = '{8'h12, 8'h19, 8'h79, 8'h40, 16'h5410, 1'b0, 1'b1};
        tbl[5] = '{8'h80, 8'h90, 8'hF8, 8'h82, 16'h8976, 1'b0, 1'b1};
        tbl[6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 16'h0000, 1'b0, 1'b0};
        tbl[8] = '{8'h8E, 8'h8E, 8'h8E, 8'h8E, 16'hFFFF, 1'b0, 1'b1};

        reset_p = 1'b1;
        com     = 4'hF;
        seg_7   = 8'hFF;
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_fv",    32'(frame_valid), 32'h0);
        chk("rst_err",   32'(frame_err), 32'h0);
        chk("rst_chg",   32'(value_changed), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);
        chk("rst_mask",  32'(digit_mask), 32'h0);

        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].s3, tbl[i].s2, tbl[i].s1, tbl[i].s0);
            check_one_frame($sformatf("tbl%0d", i), tbl[i].v, tbl[i].e, tbl[i].c);
        end

        // Dwells shorter than the settle window never capture
        dwell(4'b0111, 8'hC0, 3);
        dwell(4'b1011, 8'hF9, 3);
        dwell(4'b1101, 8'hA4, 3);
        dwell(4'b1110, 8'hB0, 3);
        dwell(4'b1111, 8'hFF, 2);
        chk("short_mask",   32'(digit_mask), 32'h0);
        chk("short_frames", 32'(obs_q.size()), 32'd0);
        chk("short_stale",  32'(stale), 32'h0);
        k = 0;
        while (!stale && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("stale_set",    32'(stale), 32'h1);
        chk("stale_timing", 32'(k >= 38 && k <= 48), 32'h1);
        chk("stale_keep",   32'(value), 32'hFFFF);

        // Partial frame discarded by timeout
        dwell(4'b0111, 8'h92, 10);
        dwell(4'b1011, 8'h99, 10);
        chk("part_mask", 32'(digit_mask), 32'hC);
        dwell(4'b1111, 8'hFF, 75);
        chk("tmo_mask", 32'(digit_mask), 32'h0);
        send_frame(8'h80, 8'h80, 8'h80, 8'h80);
        check_one_frame("after_tmo", 16'h8888, 1'b0, 1'b1);
        chk("stale_clr", 32'(stale), 32'h0);

        // Re-capture of digit0: latest pattern wins
        dwell(4'b1110, 8'hC0, 10);
        dwell(4'b1101, 8'hF9, 10);
        chk("recap_mask1", 32'(digit_mask), 32'h3);
        dwell(4'b1110, 8'h80, 10);
        chk("recap_mask2", 32'(digit_mask), 32'h3);
        dwell(4'b1011, 8'h99, 10);
        dwell(4'b0111, 8'h92, 10);
        dwell(4'b1111, 8'hFF, 3);
        check_one_frame("recap", 16'h5418, 1'b0, 1'b1);

        // Reset mid-frame
        dwell(4'b0111, 8'h88, 10);
        dwell(4'b1011, 8'h83, 10);
        chk("pre_rst_mask", 32'(digit_mask), 32'hC);
        com     = 4'hF;
        seg_7   = 8'hFF;
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        chk("mid_rst_mask",  32'(digit_mask), 32'h0);
        chk("mid_rst_value", 32'(value), 32'h0);
        obs_q.delete();
        send_frame(8'h88, 8'h83, 8'hC6, 8'hA1);
        check_one_frame("post_rst", 16'hABCD, 1'b0, 1'b1);

        // Randomized dwells against a frame-level reference model
        reset_p = 1'b1;
        dwell(4'hF, 8'hFF, 2);
        reset_p = 1'b0;
        dwell(4'hF, 8'hFF, 1);
        obs_q.delete();
        exp_q.delete();
        for (int d = 0; d < 4; d++) m_nib[d] = 4'h0;
        m_mask = 4'h0;
        m_err  = 1'b0;
        m_val  = 16'h0;
        prev_c = 4'hF;
        prev_s = 8'hFF;
        nc     = 0;
        for (int n = 0; n < 220; n++) begin
            kind = (nc >= 2) ? 0 : int'($urandom_range(0, 3));
            rs = pat[$urandom_range(0, 15)];
            if ($urandom_range(0, 1) == 1) rs[7] = 1'b0;
            if ($urandom_range(0, 7) == 0) rs = 8'($urandom);
            if (kind == 3) begin
                rc   = blanks[$urandom_range(0, 3)];
                hold = int'($urandom_range(8, 10));
            end else begin
                dig  = int'($urandom_range(0, 3));
                rc   = ~(4'b0001 << dig);
                hold = (kind == 2) ? int'($urandom_range(1, 3)) : int'($urandom_range(8, 14));
            end
            if (rc == prev_c && rs == prev_s) rs = ~rs;
            dwell(rc, rs, hold);
            prev_c = rc;
            prev_s = rs;
            capt = 1'b0;
            for (int d = 0; d < 4; d++) begin
                if (rc == ~(4'b0001 << d) && hold >= 8) begin
                    capt = 1'b1;
                    ref_decode(rs, h, ok);
                    m_nib[d]  = h;
                    m_mask[d] = 1'b1;
                    if (!ok) m_err = 1'b1;
                end
            end
            nc = capt ? 0 : nc + 1;
            if (m_mask == 4'hF) begin
                m_word = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                exp_q.push_back('{m_word, m_err, !m_err && (m_word != m_val)});
                m_val  = m_word;
                m_mask = 4'h0;
                m_err  = 1'b0;
            end
        end
        dwell(4'hF, 8'hFF, 5);
        chk("rnd_frames", 32'(obs_q.size()), 32'(exp_q.size()));
        k = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            frame_t fo, fe;
            fo = obs_q.pop_front();
            fe = exp_q.pop_front();
            chk($sformatf("rnd%0d_value", k), 32'(fo.v), 32'(fe.v));
            chk($sformatf("rnd%0d_err", k),   32'(fo.e), 32'(fe.e));
            chk($sformatf("rnd%0d_chg", k),   32'(fo.c), 32'(fe.c));
            k++;
        end
        chk("stray_pulses", 32'(stray), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
